// File: rtl/combiner_pkg.sv
// Shared definitions for the combiner sweep/track sequencer: state
// encodings, options-register bit positions and sweep-limit alignment.
package combiner_pkg;

    // Sequencer states; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        VERIFY = 2'd2,
        TRACK  = 2'd3
    } state_e;

    // Bit positions of the two control bits in the combiner options register.
    localparam int OPT_ENABLE       = 0;
    localparam int OPT_SWEEP_ENABLE = 1;
    localparam int OPT_W            = 2;

    // The sweep-limit field is the upper part of the phase word:
    // L = {1'b0, sweepLimit, LIMIT_SHIFT'b0}.
    localparam int LIMIT_SHIFT = 15;

    // Width of the saturating TRACK-entry counter.
    localparam int LOCK_COUNT_W = 8;

endpackage

// File: rtl/combiner_sweep_ctrl_if.sv
// Register-block / phase-loop side of the sweep sequencer. The master
// modport belongs to whoever supplies the control fields and lock status;
// the slave modport belongs to the sequencer itself.
interface combiner_sweep_ctrl_if #(
    parameter int PHASE_W = 32,
    parameter int LIMIT_W = 16
);
    import combiner_pkg::*;

    // Control fields and status toward the sequencer.
    logic                    ce;
    logic                    enable;
    logic                    sweepEnable;
    logic [PHASE_W-1:0]      sweepRate;
    logic [LIMIT_W-1:0]      sweepLimit;
    logic                    locked;

    // Sequencer results toward the phase-loop datapath.
    logic [PHASE_W-1:0]      sweepOffset;
    logic                    loopEnable;
    logic                    loopReset;
    logic                    sweepActive;
    logic [1:0]              state;
    logic [LOCK_COUNT_W-1:0] lockCount;

    modport master (
        output ce, enable, sweepEnable, sweepRate, sweepLimit, locked,
        input  sweepOffset, loopEnable, loopReset, sweepActive, state, lockCount
    );

    modport slave (
        input  ce, enable, sweepEnable, sweepRate, sweepLimit, locked,
        output sweepOffset, loopEnable, loopReset, sweepActive, state, lockCount
    );

endinterface

// File: rtl/combiner_dwell_cnt.sv
// Dwell counter: counts ce-qualified increment requests, clears
// synchronously (clear wins and does not need ce), and flags the last
// count of the dwell window so the owner can act on that sample.
module combiner_dwell_cnt #(
    parameter int DWELL = 16
) (
    input  logic clk,
    input  logic resetN,
    input  logic ce,
    input  logic clr,
    input  logic inc,
    output logic terminal
);
    localparam int          CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    // Count register: clear has priority, otherwise step on qualified increments.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (ce && inc && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/combiner_sweep_ctrl.sv
// Acquisition/track sequencer for the diversity-combiner phase loop.
// Sweeps a triangular phase offset within +/-L until lock is reported,
// qualifies lock over a dwell window, holds the loop in TRACK, and goes
// back to sweeping after a sustained loss of lock.
module combiner_sweep_ctrl
    import combiner_pkg::*;
#(
    parameter int PHASE_W      = 32,
    parameter int LIMIT_W      = 16,
    parameter int LOCK_DWELL   = 1024,
    parameter int UNLOCK_DWELL = 256
) (
    input  logic                  clk,
    input  logic                  resetN,
    combiner_sweep_ctrl_if.slave  bus
);
    // Two guard bits: offset may sit anywhere in the phase range when L is
    // reduced, and offset - rate must never wrap before the clamp compare.
    localparam int EXT_W = PHASE_W + 2;

    state_e                  state, stateNxt;
    logic [PHASE_W-1:0]      offset, offsetNxt;
    logic                    dirUp, dirUpNxt;
    logic [LOCK_COUNT_W-1:0] lockCount, lockCountNxt;
    logic                    loopReset, loopResetNxt;

    logic [OPT_W-1:0]        options;
    logic                    optEnable, optSweep;

    logic                    lockClr, lockInc, lockTerm;
    logic                    unlockClr, unlockInc, unlockTerm;

    logic signed [EXT_W-1:0] limPos, limNeg, offExt, rateExt, stepNxt;
    logic [PHASE_W-1:0]      sweptOffset;
    logic                    sweptDirUp;

    // Repack the two control bits as they sit in the options register.
    always_comb begin
        options                   = '0;
        options[OPT_ENABLE]       = bus.enable;
        options[OPT_SWEEP_ENABLE] = bus.sweepEnable;
        optEnable                 = options[OPT_ENABLE];
        optSweep                  = options[OPT_SWEEP_ENABLE];
    end

    // One triangle-sweep step with clamping and direction reversal at +/-L.
    // NOTE: every variable driven in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        limPos = '0;
        limPos[LIMIT_SHIFT +: LIMIT_W] = bus.sweepLimit;
        limNeg  = -limPos;
        offExt  = {{2{offset[PHASE_W-1]}}, offset};
        rateExt = {2'b00, bus.sweepRate};
        stepNxt = dirUp ? (offExt + rateExt) : (offExt - rateExt);

        sweptOffset = stepNxt[PHASE_W-1:0];
        sweptDirUp  = dirUp;
        if (stepNxt > limPos) begin
            sweptOffset = limPos[PHASE_W-1:0];
            sweptDirUp  = 1'b0;
        end else if (stepNxt < limNeg) begin
            sweptOffset = limNeg[PHASE_W-1:0];
            sweptDirUp  = 1'b1;
        end
    end

    // Next-state and datapath decisions; enable drop overrides everything
    // and does not wait for ce.
    always_comb begin
        stateNxt     = state;
        offsetNxt    = offset;
        dirUpNxt     = dirUp;
        lockCountNxt = lockCount;
        loopResetNxt = 1'b0;
        lockClr      = 1'b0;
        lockInc      = 1'b0;
        unlockClr    = 1'b0;
        unlockInc    = 1'b0;

        if (!optEnable) begin
            stateNxt     = IDLE;
            offsetNxt    = '0;
            dirUpNxt     = 1'b1;
            lockClr      = 1'b1;
            unlockClr    = 1'b1;
            loopResetNxt = (state != IDLE);
        end else if (bus.ce) begin
            unique case (state)
                IDLE: begin
                    if (optSweep) begin
                        stateNxt     = SWEEP;
                        loopResetNxt = 1'b1;
                    end else begin
                        stateNxt = VERIFY;
                    end
                end
                SWEEP: begin
                    // Lock or a sweep disable freezes the offset on this edge.
                    if (bus.locked || !optSweep) begin
                        stateNxt = VERIFY;
                    end else begin
                        offsetNxt = sweptOffset;
                        dirUpNxt  = sweptDirUp;
                    end
                end
                VERIFY: begin
                    if (!bus.locked) begin
                        lockClr = 1'b1;
                        if (optSweep) begin
                            stateNxt = SWEEP;
                        end
                    end else if (lockTerm) begin
                        lockClr      = 1'b1;
                        stateNxt     = TRACK;
                        lockCountNxt = (lockCount == '1) ? lockCount
                                                          : lockCount + LOCK_COUNT_W'(1);
                    end else begin
                        lockInc = 1'b1;
                    end
                end
                TRACK: begin
                    if (bus.locked) begin
                        unlockClr = 1'b1;
                    end else if (unlockTerm) begin
                        unlockClr    = 1'b1;
                        loopResetNxt = 1'b1;
                        stateNxt     = optSweep ? SWEEP : VERIFY;
                    end else begin
                        unlockInc = 1'b1;
                    end
                end
                default: stateNxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Offset, direction, TRACK-entry count and loop-clear pulse registers.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            offset    <= '0;
            dirUp     <= 1'b1;
            lockCount <= '0;
            loopReset <= 1'b0;
        end else begin
            offset    <= offsetNxt;
            dirUp     <= dirUpNxt;
            lockCount <= lockCountNxt;
            loopReset <= loopResetNxt;
        end
    end

    // Lock qualification window, counted while in VERIFY.
    combiner_dwell_cnt #(
        .DWELL (LOCK_DWELL)
    ) u_lock_dwell (
        .clk      (clk),
        .resetN   (resetN),
        .ce       (bus.ce),
        .clr      (lockClr),
        .inc      (lockInc),
        .terminal (lockTerm)
    );

    // Loss-of-lock window, counted while in TRACK.
    combiner_dwell_cnt #(
        .DWELL (UNLOCK_DWELL)
    ) u_unlock_dwell (
        .clk      (clk),
        .resetN   (resetN),
        .ce       (bus.ce),
        .clr      (unlockClr),
        .inc      (unlockInc),
        .terminal (unlockTerm)
    );

    assign bus.sweepOffset = offset;
    assign bus.loopEnable  = (state != IDLE);
    assign bus.loopReset   = loopReset;
    assign bus.sweepActive = (state == SWEEP);
    assign bus.state       = state;
    assign bus.lockCount   = lockCount;

endmodule

// File: tb/tb_combiner_sweep_ctrl.sv
// Directed bench for combiner_sweep_ctrl with short dwell windows
// (lock 16, unlock 8). Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point.
module tb_combiner_sweep_ctrl;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;

    combiner_sweep_ctrl_if #(.PHASE_W(32), .LIMIT_W(16)) bus ();

    combiner_sweep_ctrl #(
        .PHASE_W      (32),
        .LIMIT_W      (16),
        .LOCK_DWELL   (16),
        .UNLOCK_DWELL (8)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    logic [31:0] tri_exp [11];

    initial begin
        checks = 0;
        errors = 0;
        tri_exp = '{32'h0100_0000, 32'h0200_0000, 32'h0200_0000, 32'h0100_0000,
                    32'h0000_0000, 32'hFF00_0000, 32'hFE00_0000, 32'hFE00_0000,
                    32'hFF00_0000, 32'h0000_0000, 32'h0100_0000};

        // Reset with everything idle.
        resetN          = 1'b0;
        bus.ce          = 1'b0;
        bus.enable      = 1'b0;
        bus.sweepEnable = 1'b0;
        bus.sweepRate   = '0;
        bus.sweepLimit  = '0;
        bus.locked      = 1'b0;
        tick(3);
        check("rst_state",  32'(bus.state), 32'd0);
        check("rst_offset", bus.sweepOffset, 32'd0);
        check("rst_loopen", 32'(bus.loopEnable), 32'd0);
        check("rst_looprst", 32'(bus.loopReset), 32'd0);
        check("rst_active", 32'(bus.sweepActive), 32'd0);
        check("rst_lockcnt", 32'(bus.lockCount), 32'd0);

        // Enable with sweep: IDLE -> SWEEP with a one-cycle loop clear.
        resetN          = 1'b1;
        bus.enable      = 1'b1;
        bus.sweepEnable = 1'b1;
        bus.ce          = 1'b1;
        bus.sweepRate   = 32'h0100_0000;
        bus.sweepLimit  = 16'h0400;
        tick(1);
        check("en_state",   32'(bus.state), 32'd1);
        check("en_looprst", 32'(bus.loopReset), 32'd1);
        check("en_offset",  bus.sweepOffset, 32'd0);
        check("en_active",  32'(bus.sweepActive), 32'd1);
        check("en_loopen",  32'(bus.loopEnable), 32'd1);

        // Triangle sweep across +/-0x0200_0000.
        for (int i = 0; i < 11; i++) begin
            tick(1);
            check($sformatf("tri_%0d", i), bus.sweepOffset, tri_exp[i]);
            if (i == 0) check("tri_looprst_low", 32'(bus.loopReset), 32'd0);
        end

        // Lock at +0x0100_0000, glitch low on the 10th VERIFY sample.
        bus.locked = 1'b1;
        tick(1);
        check("lock_state",  32'(bus.state), 32'd2);
        check("lock_offset", bus.sweepOffset, 32'h0100_0000);
        tick(9);
        check("lock_dwell9", 32'(bus.state), 32'd2);
        bus.locked = 1'b0;
        tick(1);
        check("glitch_state",  32'(bus.state), 32'd1);
        check("glitch_offset", bus.sweepOffset, 32'h0100_0000);
        tick(1);
        check("resweep_offset", bus.sweepOffset, 32'h0200_0000);
        bus.locked = 1'b1;
        tick(1);
        check("relock_state", 32'(bus.state), 32'd2);
        tick(15);
        check("verify_15", 32'(bus.state), 32'd2);
        tick(1);
        check("track_state",   32'(bus.state), 32'd3);
        check("track_lockcnt", 32'(bus.lockCount), 32'd1);
        check("track_active",  32'(bus.sweepActive), 32'd0);
        check("track_loopen",  32'(bus.loopEnable), 32'd1);
        check("track_offset",  bus.sweepOffset, 32'h0200_0000);

        // Loss of lock: 7 low then high keeps TRACK; 8 low leaves it.
        bus.locked = 1'b0;
        tick(7);
        check("unlock7_state", 32'(bus.state), 32'd3);
        bus.locked = 1'b1;
        tick(1);
        check("unlock_recover", 32'(bus.state), 32'd3);
        bus.locked = 1'b0;
        tick(7);
        check("unlock7b_state", 32'(bus.state), 32'd3);
        tick(1);
        check("unlock8_state",   32'(bus.state), 32'd1);
        check("unlock8_looprst", 32'(bus.loopReset), 32'd1);
        check("unlock8_offset",  bus.sweepOffset, 32'h0200_0000);
        tick(1);
        check("resume_looprst", 32'(bus.loopReset), 32'd0);
        check("resume_offset0", bus.sweepOffset, 32'h0200_0000);
        tick(1);
        check("resume_offset1", bus.sweepOffset, 32'h0100_0000);

        // ce at 1-in-4: offset only moves on ce edges.
        bus.ce = 1'b0;
        tick(3);
        check("ce_hold0", bus.sweepOffset, 32'h0100_0000);
        bus.ce = 1'b1;
        tick(1);
        check("ce_step0", bus.sweepOffset, 32'h0000_0000);
        bus.ce = 1'b0;
        tick(3);
        check("ce_hold1", bus.sweepOffset, 32'h0000_0000);
        bus.ce = 1'b1;
        tick(1);
        check("ce_step1", bus.sweepOffset, 32'hFF00_0000);

        // Sweep disable in SWEEP -> VERIFY, then enable drop with ce=0.
        bus.sweepEnable = 1'b0;
        tick(1);
        check("swdis_state",  32'(bus.state), 32'd2);
        check("swdis_offset", bus.sweepOffset, 32'hFF00_0000);
        bus.locked = 1'b1;
        tick(3);
        check("partial_state", 32'(bus.state), 32'd2);
        bus.ce     = 1'b0;
        bus.enable = 1'b0;
        tick(1);
        check("endrop_state",   32'(bus.state), 32'd0);
        check("endrop_offset",  bus.sweepOffset, 32'd0);
        check("endrop_looprst", 32'(bus.loopReset), 32'd1);
        check("endrop_loopen",  32'(bus.loopEnable), 32'd0);
        tick(1);
        check("endrop_pulse_end", 32'(bus.loopReset), 32'd0);

        // Re-enable without sweep: full dwell needed, no partial credit.
        bus.enable = 1'b1;
        bus.ce     = 1'b1;
        tick(1);
        check("noswp_state",   32'(bus.state), 32'd2);
        check("noswp_looprst", 32'(bus.loopReset), 32'd0);
        tick(15);
        check("noswp_15", 32'(bus.state), 32'd2);
        tick(1);
        check("noswp_track",   32'(bus.state), 32'd3);
        check("noswp_lockcnt", 32'(bus.lockCount), 32'd2);

        // Reset mid-TRACK clears the entry count.
        resetN = 1'b0;
        tick(1);
        check("rst2_state",   32'(bus.state), 32'd0);
        check("rst2_lockcnt", 32'(bus.lockCount), 32'd0);

        // sweepLimit = 0: offset pinned at zero.
        resetN          = 1'b1;
        bus.sweepEnable = 1'b1;
        bus.locked      = 1'b0;
        bus.sweepLimit  = 16'h0000;
        bus.sweepRate   = 32'h0100_0000;
        tick(1);
        check("l0_state", 32'(bus.state), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("l0_offset_%0d", i), bus.sweepOffset, 32'd0);
        end

        // Huge rate: offset alternates between +L and -L without wrapping.
        bus.sweepRate  = 32'hFFFF_FFFF;
        bus.sweepLimit = 16'h0400;
        tick(1);
        check("big_0", bus.sweepOffset, 32'h0200_0000);
        tick(1);
        check("big_1", bus.sweepOffset, 32'hFE00_0000);
        tick(1);
        check("big_2", bus.sweepOffset, 32'h0200_0000);
        tick(1);
        check("big_3", bus.sweepOffset, 32'hFE00_0000);

        // Limit reduced below |offset|: clamp on the next step.
        bus.sweepLimit = 16'h0200;
        bus.sweepRate  = 32'h0080_0000;
        tick(1);
        check("shrink_clamp", bus.sweepOffset, 32'hFF00_0000);

        // Saturation: 300 VERIFY->TRACK->VERIFY cycles.
        bus.sweepEnable = 1'b0;
        bus.locked      = 1'b1;
        tick(1);
        check("sat_entry", 32'(bus.state), 32'd2);
        for (int i = 0; i < 300; i++) begin
            bus.locked = 1'b1;
            tick(16);
            if (i == 0) check("sat_first", 32'(bus.lockCount), 32'd1);
            bus.locked = 1'b0;
            tick(8);
        end
        check("sat_lockcnt", 32'(bus.lockCount), 32'd255);
        check("sat_state",   32'(bus.state), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
